// File: rtl/multi_door_access_ctrl.sv
// Multi-door passage controller: per-door direction FSM with transit timeout,
// plus a shared saturating occupancy counter with full/empty flags.
module multi_door_access_ctrl #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned CAPACITY    = 200,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned TMR_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  s1,
    input  logic [N_CH-1:0]  s2,
    output logic [N_CH-1:0]  v,
    output logic [N_CH-1:0]  r,
    output logic [N_CH-1:0]  fault,
    output logic [CNT_W-1:0] ocupacion,
    output logic             lleno,
    output logic             vacio,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned RAW_W = CNT_W + 5;
    localparam int unsigned EVT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENT1  = 3'd1,
        S_ENT12 = 3'd2,
        S_EXT1  = 3'd3,
        S_EXT12 = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t            state_q [N_CH];
    state_t            state_d [N_CH];
    logic [TMR_W-1:0]  timer_q [N_CH];
    logic [TMR_W-1:0]  timer_d [N_CH];
    logic [N_CH-1:0]   entry_evt_c;
    logic [N_CH-1:0]   exit_evt_c;

    logic [N_CH-1:0]   v_d;
    logic [N_CH-1:0]   r_d;
    logic [N_CH-1:0]   fault_d;

    logic [EVT_W-1:0]        n_in_c;
    logic [EVT_W-1:0]        n_out_c;
    logic signed [RAW_W-1:0] raw_c;
    logic                    ovf_d;
    logic                    unf_d;
    logic [CNT_W-1:0]        ocup_d;
    logic                    lleno_d;
    logic                    vacio_d;

    // Per-door state and transit timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                state_q[i] <= S_IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
            end
        end
    end

    // Next-state, timer and completion events; timeout overrides sensors
    always_comb begin
        entry_evt_c = '0;
        exit_evt_c  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = '0;
            unique case (state_q[i])
                S_IDLE: begin
                    unique case ({s2[i], s1[i]})
                        2'b01:   state_d[i] = S_ENT1;
                        2'b10:   state_d[i] = S_EXT1;
                        2'b11:   state_d[i] = S_FAULT;
                        default: state_d[i] = S_IDLE;
                    endcase
                end
                S_ENT1: begin
                    unique case ({s2[i], s1[i]})
                        2'b11:   state_d[i] = S_ENT12;
                        2'b00:   state_d[i] = S_IDLE;
                        2'b10:   state_d[i] = S_FAULT;
                        default: state_d[i] = S_ENT1;
                    endcase
                end
                S_ENT12: begin
                    if ({s2[i], s1[i]} == 2'b00) state_d[i] = S_IDLE;
                end
                S_EXT1: begin
                    unique case ({s2[i], s1[i]})
                        2'b11:   state_d[i] = S_EXT12;
                        2'b00:   state_d[i] = S_IDLE;
                        2'b01:   state_d[i] = S_FAULT;
                        default: state_d[i] = S_EXT1;
                    endcase
                end
                S_EXT12: begin
                    if ({s2[i], s1[i]} == 2'b00) state_d[i] = S_IDLE;
                end
                S_FAULT: begin
                    if ({s2[i], s1[i]} == 2'b00) state_d[i] = S_IDLE;
                end
                default: state_d[i] = S_IDLE;
            endcase

            if ((state_q[i] == S_ENT1 || state_q[i] == S_ENT12 ||
                 state_q[i] == S_EXT1 || state_q[i] == S_EXT12) &&
                timer_q[i] == TMR_W'(TIMEOUT_CYC - 1)) begin
                state_d[i] = S_FAULT;
            end

            if (state_d[i] == state_q[i] &&
                (state_q[i] == S_ENT1 || state_q[i] == S_ENT12 ||
                 state_q[i] == S_EXT1 || state_q[i] == S_EXT12)) begin
                timer_d[i] = timer_q[i] + TMR_W'(1);
            end

            entry_evt_c[i] = (state_q[i] == S_ENT12) && (state_d[i] == S_IDLE);
            exit_evt_c[i]  = (state_q[i] == S_EXT12) && (state_d[i] == S_IDLE);
        end
    end

    // Occupancy update: signed sum of all same-cycle events, clamped to [0, CAPACITY]
    always_comb begin
        n_in_c  = '0;
        n_out_c = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            n_in_c  = n_in_c  + EVT_W'(entry_evt_c[i]);
            n_out_c = n_out_c + EVT_W'(exit_evt_c[i]);
        end
        raw_c = $signed(RAW_W'(ocupacion)) + $signed(RAW_W'(n_in_c))
              - $signed(RAW_W'(n_out_c));
        ovf_d = raw_c > $signed(RAW_W'(CAPACITY));
        unf_d = raw_c[RAW_W-1];
        if (ovf_d) begin
            ocup_d = CNT_W'(CAPACITY);
        end else if (unf_d) begin
            ocup_d = '0;
        end else begin
            ocup_d = raw_c[CNT_W-1:0];
        end
        lleno_d = (ocup_d == CNT_W'(CAPACITY));
        vacio_d = (ocup_d == '0);
    end

    // Light and fault decode from the next state so outputs line up with the state register
    always_comb begin
        v_d     = '0;
        r_d     = '0;
        fault_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            v_d[i]     = (state_d[i] == S_ENT12 && !lleno_d) || (state_d[i] == S_EXT12);
            r_d[i]     = (state_d[i] == S_FAULT) || (state_d[i] == S_ENT12 && lleno_d);
            fault_d[i] = (state_d[i] == S_FAULT) && (state_q[i] != S_FAULT);
        end
    end

    // Output and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v         <= '0;
            r         <= '0;
            fault     <= '0;
            ocupacion <= '0;
            lleno     <= 1'b0;
            vacio     <= 1'b1;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            v         <= v_d;
            r         <= r_d;
            fault     <= fault_d;
            ocupacion <= ocup_d;
            lleno     <= lleno_d;
            vacio     <= vacio_d;
            ovf       <= ovf_d;
            unf       <= unf_d;
        end
    end

endmodule
